pipeline_exec_controller: RTL and testbench

PIPELINE_EXEC_CONTROLLER -- requirements
Module: pipeline_exec_controller

---
 rtl/pipeline_exec_controller_if.sv | 28 ++
 rtl/pipeline_exec_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_exec_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_exec_controller_if.sv
// Control handshake between the pipeline execution controller and its sequencer.
// The master drives the run/step/abort requests and pipeline status; the slave is the controller.
interface pipeline_exec_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_start;
  logic             i_mode_step;
  logic             i_step;
  logic             i_abort;
  logic             i_halt_fetched;
  logic             i_hazard_stall;
  logic             o_PC_write;
  logic             o_pipe_enable;
  logic             o_step_done;
  logic             o_halted;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;

  modport master (
    output i_start, i_mode_step, i_step, i_abort, i_halt_fetched, i_hazard_stall,
    input  o_PC_write, o_pipe_enable, o_step_done, o_halted, o_state, o_cycle_count
  );

  modport slave (
    input  i_start, i_mode_step, i_step, i_abort, i_halt_fetched, i_hazard_stall,
    output o_PC_write, o_pipe_enable, o_step_done, o_halted, o_state, o_cycle_count
  );
endinterface

// File: rtl/pipeline_exec_controller.sv
// Run/step/drain/halt sequencer for a 5-stage pipeline: gates PC writes and pipeline
// register enables, and counts enabled cycles since the last start.
module pipeline_exec_controller #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  pipeline_exec_controller_if.slave bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_prev_q, step_prev_d;
  logic               step_done_q, step_done_d;
  logic               step_rise_c;
  logic               pipe_en_c;
  logic               pc_write_c;

  // Enable decode: a stall or a fetched HALT only blocks the PC, never the pipeline.
  always_comb begin
    pipe_en_c  = 1'b0;
    pc_write_c = 1'b0;
    case (state_q)
      S_RUN, S_STEP_EXEC: begin
        pipe_en_c  = 1'b1;
        pc_write_c = !bus.i_hazard_stall && !bus.i_halt_fetched;
      end
      S_DRAIN: pipe_en_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    step_prev_d = bus.i_step;
    step_done_d = (state_q == S_STEP_EXEC);
    step_rise_c = bus.i_step && !step_prev_q;

    if (pipe_en_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.i_abort) begin
      state_d = S_IDLE;
      drain_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            cnt_d   = '0;
            state_d = bus.i_mode_step ? S_STEP_WAIT : S_RUN;
          end
        end
        S_RUN: begin
          if (bus.i_halt_fetched) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end
        S_STEP_WAIT: begin
          if (step_rise_c) begin
            state_d = S_STEP_EXEC;
          end
        end
        S_STEP_EXEC: begin
          if (bus.i_halt_fetched) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end else begin
            state_d = S_STEP_WAIT;
          end
        end
        S_DRAIN: begin
          // Last drain cycle is the one that sees the counter at 1.
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = S_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
        S_HALTED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      step_prev_q <= step_prev_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.o_PC_write    = pc_write_c;
  assign bus.o_pipe_enable = pipe_en_c;
  assign bus.o_halted      = (state_q == S_HALTED);
  assign bus.o_step_done   = step_done_q;
  assign bus.o_state       = state_q;
  assign bus.o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed scenarios plus randomized stimulus for pipeline_exec_controller, checked every cycle
// against a behavioural model; a second CNT_W=4 instance shares the inputs to exercise saturation.
module tb_pipeline_exec_controller;

  localparam int unsigned DC = 4;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_SWAIT = 2, ST_SEXEC = 3, ST_DRAIN = 4, ST_HALT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_exec_controller_if #(.CNT_W(32)) bus ();
  pipeline_exec_controller_if #(.CNT_W(4))  sbus ();

  assign sbus.i_start        = bus.i_start;
  assign sbus.i_mode_step    = bus.i_mode_step;
  assign sbus.i_step         = bus.i_step;
  assign sbus.i_abort        = bus.i_abort;
  assign sbus.i_halt_fetched = bus.i_halt_fetched;
  assign sbus.i_hazard_stall = bus.i_hazard_stall;

  pipeline_exec_controller #(.DRAIN_CYCLES(DC), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipeline_exec_controller #(.DRAIN_CYCLES(DC), .CNT_W(4)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  int     m_st;
  int     m_drain;
  longint m_cnt;
  bit     m_prev;
  bit     m_done;
  int     n_pcw, n_done, n_exec;
  logic [31:0] snap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit m_enabled();
    return (m_st == ST_RUN) || (m_st == ST_SEXEC) || (m_st == ST_DRAIN);
  endfunction

  // Behavioural model: advance one clock using the inputs applied this cycle.
  task automatic model_step();
    bit en;
    if (!rst) begin
      m_st = ST_IDLE; m_drain = 0; m_cnt = 0; m_prev = 0; m_done = 0;
      return;
    end
    en     = m_enabled();
    m_done = (m_st == ST_SEXEC);
    if (en) m_cnt++;
    if (bus.i_abort) begin
      m_st = ST_IDLE;
    end else if (m_st == ST_IDLE) begin
      if (bus.i_start) begin
        m_cnt = 0;
        m_st  = bus.i_mode_step ? ST_SWAIT : ST_RUN;
      end
    end else if (m_st == ST_RUN) begin
      if (bus.i_halt_fetched) begin m_st = ST_DRAIN; m_drain = DC; end
    end else if (m_st == ST_SWAIT) begin
      if (bus.i_step && !m_prev) m_st = ST_SEXEC;
    end else if (m_st == ST_SEXEC) begin
      if (bus.i_halt_fetched) begin m_st = ST_DRAIN; m_drain = DC; end
      else m_st = ST_SWAIT;
    end else if (m_st == ST_DRAIN) begin
      m_drain--;
      if (m_drain <= 0) m_st = ST_HALT;
    end
    m_prev = bus.i_step;
  endtask

  task automatic tick();
    bit exp_pe, exp_pcw;
    longint sat32, sat4;
    @(negedge clk);
    exp_pe  = m_enabled();
    exp_pcw = ((m_st == ST_RUN) || (m_st == ST_SEXEC)) && !bus.i_hazard_stall && !bus.i_halt_fetched;
    sat32   = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
    sat4    = (m_cnt > 15) ? 15 : m_cnt;
    chk("state",     64'(bus.o_state),        64'(m_st));
    chk("pipe_en",   64'(bus.o_pipe_enable),  64'(exp_pe));
    chk("pc_write",  64'(bus.o_PC_write),     64'(exp_pcw));
    chk("halted",    64'(bus.o_halted),       64'(m_st == ST_HALT));
    chk("step_done", 64'(bus.o_step_done),    64'(m_done));
    chk("cnt",       64'(bus.o_cycle_count),  64'(sat32));
    chk("cnt_sat4",  64'(sbus.o_cycle_count), 64'(sat4));
    chk("sat4_state", 64'(sbus.o_state),      64'(m_st));
    if (bus.o_PC_write === 1'b1) n_pcw++;
    if (bus.o_step_done === 1'b1) n_done++;
    if (bus.o_state === 3'd3) n_exec++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.i_start = 0; bus.i_mode_step = 0; bus.i_step = 0;
    bus.i_abort = 0; bus.i_halt_fetched = 0; bus.i_hazard_stall = 0;
    m_st = ST_IDLE; m_drain = 0; m_cnt = 0; m_prev = 0; m_done = 0;
    n_pcw = 0; n_done = 0; n_exec = 0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Continuous run, HALT on the 10th RUN cycle
    bus.i_start = 1; bus.i_mode_step = 0; tick(); bus.i_start = 0;
    n_pcw = 0;
    repeat (9) tick();
    bus.i_halt_fetched = 1; tick(); bus.i_halt_fetched = 0;
    repeat (DC) tick();
    chk("run_pcw_cycles", 64'(n_pcw), 64'd9);
    chk("run_halt_state", 64'(bus.o_state), 64'd5);
    chk("run_halt_cnt", 64'(bus.o_cycle_count), 64'd14);
    bus.i_start = 1; repeat (2) tick(); bus.i_start = 0;
    chk("halt_hold_cnt", 64'(bus.o_cycle_count), 64'd14);
    bus.i_abort = 1; tick(); bus.i_abort = 0;
    chk("abort_idle", 64'(bus.o_state), 64'd0);

    // Step mode: three pulses, the second held for 5 cycles
    bus.i_start = 1; bus.i_mode_step = 1; tick(); bus.i_start = 0; bus.i_mode_step = 0;
    n_done = 0; n_exec = 0;
    bus.i_step = 1; tick(); bus.i_step = 0; repeat (2) tick();
    bus.i_step = 1; repeat (5) tick(); bus.i_step = 0; repeat (2) tick();
    bus.i_step = 1; tick(); bus.i_step = 0; repeat (3) tick();
    chk("step_exec_cycles", 64'(n_exec), 64'd3);
    chk("step_done_pulses", 64'(n_done), 64'd3);
    chk("step_cnt", 64'(bus.o_cycle_count), 64'd3);
    chk("step_wait_state", 64'(bus.o_state), 64'd2);

    // HALT fetched during STEP_EXEC, later step edges ignored
    n_done = 0; n_exec = 0;
    bus.i_step = 1; tick();
    bus.i_step = 0; bus.i_halt_fetched = 1; tick(); bus.i_halt_fetched = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_step = i[0];
      tick();
    end
    bus.i_step = 0; tick();
    chk("step_halt_state", 64'(bus.o_state), 64'd5);
    chk("step_halt_cnt", 64'(bus.o_cycle_count), 64'd8);
    chk("step_halt_done", 64'(n_done), 64'd1);
    chk("step_halt_exec", 64'(n_exec), 64'd1);
    bus.i_abort = 1; tick(); bus.i_abort = 0;

    // Two-cycle stall in RUN
    bus.i_start = 1; tick(); bus.i_start = 0;
    repeat (3) tick();
    snap = bus.o_cycle_count; n_pcw = 0;
    bus.i_hazard_stall = 1; repeat (2) tick(); bus.i_hazard_stall = 0;
    chk("stall_pcw", 64'(n_pcw), 64'd0);
    chk("stall_cnt", 64'(bus.o_cycle_count), 64'(snap) + 64'd2);

    // Simultaneous halt and stall, then abort mid-drain
    bus.i_halt_fetched = 1; bus.i_hazard_stall = 1; tick();
    bus.i_halt_fetched = 0; bus.i_hazard_stall = 0;
    chk("halt_stall_drain", 64'(bus.o_state), 64'd4);
    repeat (2) tick();
    bus.i_abort = 1; tick(); bus.i_abort = 0;
    snap = bus.o_cycle_count;
    repeat (3) tick();
    chk("abort_drain_idle", 64'(bus.o_state), 64'd0);
    chk("abort_cnt_held", 64'(bus.o_cycle_count), 64'(snap));

    // Reset mid-RUN
    bus.i_start = 1; tick(); bus.i_start = 0;
    repeat (3) tick();
    rst = 0; tick(); rst = 1;
    chk("rst_state", 64'(bus.o_state), 64'd0);
    chk("rst_cnt", 64'(bus.o_cycle_count), 64'd0);
    chk("rst_pipe_en", 64'(bus.o_pipe_enable), 64'd0);
    repeat (3) tick();
    chk("rst_no_activity", 64'(bus.o_state), 64'd0);

    // Saturation of the 4-bit counter
    bus.i_start = 1; tick(); bus.i_start = 0;
    repeat (20) tick();
    chk("sat4_cnt", 64'(sbus.o_cycle_count), 64'd15);
    chk("sat_main_cnt", 64'(bus.o_cycle_count), 64'd20);
    bus.i_abort = 1; tick(); bus.i_abort = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.i_start        = ($urandom_range(0, 9) == 0);
      bus.i_mode_step    = $urandom_range(0, 1) == 1;
      bus.i_step         = ($urandom_range(0, 2) == 0) ? ~bus.i_step : bus.i_step;
      bus.i_abort        = ($urandom_range(0, 49) == 0);
      bus.i_halt_fetched = ($urandom_range(0, 19) == 0);
      bus.i_hazard_stall = ($urandom_range(0, 4) == 0);
      rst                = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
